param_dual_port_memory: RTL and testbench

- Parametrised successor to the CPU's separate byte-wide instruction and data memories: one storage array of 2^ADDR_W words of DATA_W bits.
- Ports: one synchronous write port, one synchronous data-read port, and one multi-word instruction-fetch port that returns FETCH_WORDS consecutive words little-endian.
- A post-reset clear engine replaces simulation-only initial blocks, so contents are deterministic in hardware.
- Sits between the CPU core (fetch stage and load/store stage) and the program loader, which uses the write port.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_clear_fsm.sv | 50 +++++
 rtl/param_dual_port_memory.sv | 110 +++++++++++
 tb/tb_param_dual_port_memory.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types, constants and address helper for the dual-port memory.
// Rev    : 1.0  initial release
// ============================================================================
package mem_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // (base + k) mod 2^addr_w
   function automatic longint unsigned wrap_add(
      input longint unsigned base,
      input longint unsigned k,
      input int unsigned     addr_w
   );
      longint unsigned mask;
      mask = (64'd1 << addr_w) - 64'd1;
      return (base + k) & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module : mem_clear_fsm
// Brief  : Post-reset clear sequencer; sweeps every address once, then RUN.
// Rev    : 1.0  initial release
// ============================================================================
module mem_clear_fsm
   import mem_pkg::*;
#(
   parameter int ADDR_W         = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] c_last_addr = '1;

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         r_ptr   <= '0;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_ptr <= r_ptr + ADDR_W'(1);
               if (r_ptr == c_last_addr) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end
            end
            default: r_ready <= 1'b1;
         endcase
      end
   end

   assign ready    = r_ready;
   assign clr_we   = (r_state == CLEAR);
   assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/param_dual_port_memory.sv
`default_nettype none
// ============================================================================
// Module : param_dual_port_memory
// Brief  : Single array with write port, 1-cycle data read and multi-word fetch.
// Rev    : 1.0  initial release
// ============================================================================
module param_dual_port_memory
   import mem_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 8,
   parameter int FETCH_WORDS    = 2,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic                          ready,
   input  logic                          we,
   input  logic [ADDR_W-1:0]             waddr,
   input  logic [DATA_W-1:0]             din,
   input  logic                          re,
   input  logic [ADDR_W-1:0]             raddr,
   output logic [DATA_W-1:0]             dout,
   output logic                          dout_valid,
   input  logic                          fe,
   input  logic [ADDR_W-1:0]             faddr,
   output logic [FETCH_WORDS*DATA_W-1:0] fins,
   output logic                          fins_valid
);

   localparam int c_depth = 1 << ADDR_W;

   logic [DATA_W-1:0]             r_mem [0:c_depth-1];
   logic [DATA_W-1:0]             r_dout;
   logic                          r_dout_valid;
   logic [FETCH_WORDS*DATA_W-1:0] r_fins;
   logic                          r_fins_valid;

   logic                          w_ready;
   logic                          w_clr_we;
   logic [ADDR_W-1:0]             w_clr_addr;
   logic                          w_ext_we;
   logic                          w_mem_we;
   logic [ADDR_W-1:0]             w_mem_addr;
   logic [DATA_W-1:0]             w_mem_din;
   logic [DATA_W-1:0]             w_rdata;
   logic [FETCH_WORDS*DATA_W-1:0] w_fdata;

   mem_clear_fsm #(
      .ADDR_W         (ADDR_W),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (w_ready),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );

   // External requests are only honoured once the clear has finished.
   assign w_ext_we   = w_ready & we;
   assign w_mem_we   = w_ready ? we    : w_clr_we;
   assign w_mem_addr = w_ready ? waddr : w_clr_addr;
   assign w_mem_din  = w_ready ? din   : '0;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_din;
      end
   end

   assign w_rdata = (RDW_MODE == RDW_NEW && w_ext_we && waddr == raddr) ? din : r_mem[raddr];

   genvar k;
   generate
      for (k = 0; k < FETCH_WORDS; k++) begin : g_fetch
         logic [ADDR_W-1:0] w_fa;
         assign w_fa = ADDR_W'(wrap_add(64'(faddr), 64'(k), ADDR_W));
         assign w_fdata[k*DATA_W +: DATA_W] =
            (RDW_MODE == RDW_NEW && w_ext_we && waddr == w_fa) ? din : r_mem[w_fa];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_fins       <= '0;
         r_fins_valid <= 1'b0;
      end else begin
         r_dout_valid <= w_ready & re;
         r_fins_valid <= w_ready & fe;
         if (w_ready && re) begin
            r_dout <= w_rdata;
         end
         if (w_ready && fe) begin
            r_fins <= w_fdata;
         end
      end
   end

   assign ready      = w_ready;
   assign dout       = r_dout;
   assign dout_valid = r_dout_valid;
   assign fins       = r_fins;
   assign fins_valid = r_fins_valid;

endmodule
`default_nettype wire

// File: tb/tb_param_dual_port_memory.sv
`default_nettype none
// ============================================================================
// Module : tb_param_dual_port_memory
// Brief  : Directed vector bench over old-data, write-through and no-clear builds.
// Rev    : 1.0  initial release
// ============================================================================
module tb_param_dual_port_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_n2 = 1'b0;
   logic        we = 1'b0, re = 1'b0, fe = 1'b0;
   logic [7:0]  waddr = '0, din = '0, raddr = '0, faddr = '0;

   logic        rdy0, dv0, fv0, rdy1, dv1, fv1, rdy2, dv2, fv2;
   logic [7:0]  dout0, dout1, dout2;
   logic [15:0] fins0, fins1, fins2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   param_dual_port_memory #(.RDW_MODE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ready(rdy0), .we(we), .waddr(waddr), .din(din),
      .re(re), .raddr(raddr), .dout(dout0), .dout_valid(dv0),
      .fe(fe), .faddr(faddr), .fins(fins0), .fins_valid(fv0));

   param_dual_port_memory #(.RDW_MODE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ready(rdy1), .we(we), .waddr(waddr), .din(din),
      .re(re), .raddr(raddr), .dout(dout1), .dout_valid(dv1),
      .fe(fe), .faddr(faddr), .fins(fins1), .fins_valid(fv1));

   param_dual_port_memory #(.CLEAR_ON_RESET(0)) u_dut2 (
      .clk(clk), .rst_n(rst_n2), .ready(rdy2), .we(we), .waddr(waddr), .din(din),
      .re(re), .raddr(raddr), .dout(dout2), .dout_valid(dv2),
      .fe(fe), .faddr(faddr), .fins(fins2), .fins_valid(fv2));

   typedef struct {
      logic        we;
      logic [7:0]  waddr;
      logic [7:0]  din;
      logic        re;
      logic [7:0]  raddr;
      logic        fe;
      logic [7:0]  faddr;
      logic        dv;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic        fv;
      logic [15:0] f0;
      logic [15:0] f1;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we = 1'b0; re = 1'b0; fe = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n;
      int bad_valid;
      n = 0;
      bad_valid = 0;
      while (!(rdy0 && rdy1) && n < 1000) begin
         @(posedge clk); #1;
         n++;
         if (dv0 || dv1 || fv0 || fv1) bad_valid++;
      end
      idle_inputs();
      chk({name, "_clear_cycles"}, 64'(n), 64'd256);
      chk({name, "_valid_in_clear"}, 64'(bad_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //               we waddr  din   re raddr fe faddr  dv d0     d1     fv f0        f1
      vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h7F, 1'b1, 8'h7F, 1'b1, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000};
      vecs[1]  = '{1'b1, 8'h10, 8'h34, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000};
      vecs[2]  = '{1'b1, 8'h11, 8'h12, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000};
      vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00, 8'h00, 1'b1, 16'h1234, 16'h1234};
      vecs[4]  = '{1'b1, 8'hFF, 8'hAA, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'h1234, 16'h1234};
      vecs[5]  = '{1'b1, 8'h00, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 16'h1234, 16'h1234};
      vecs[6]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hAA, 8'hAA, 1'b1, 16'h55AA, 16'h55AA};
      vecs[7]  = '{1'b1, 8'h20, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'hAA, 8'hAA, 1'b0, 16'h55AA, 16'h55AA};
      vecs[8]  = '{1'b1, 8'h20, 8'hF0, 1'b1, 8'h20, 1'b1, 8'h1F, 1'b1, 8'h0F, 8'hF0, 1'b1, 16'h0F00, 16'hF000};
      vecs[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 8'hF0, 8'hF0, 1'b0, 16'h0F00, 16'hF000};
      vecs[10] = '{1'b1, 8'h30, 8'h5A, 1'b1, 8'h11, 1'b1, 8'h2F, 1'b1, 8'h12, 8'h12, 1'b1, 16'h0000, 16'h5A00};
      vecs[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h12, 8'h12, 1'b0, 16'h0000, 16'h5A00};
      vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 1'b1, 8'h30, 1'b1, 8'h5A, 8'h5A, 1'b1, 16'h005A, 16'h005A};

      // Power-on reset: outputs must be zero while held.
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 64'({rdy0, rdy1, rdy2}), 64'd0);
      chk("rst_dout", 64'({dout0, dout1, dout2}), 64'd0);
      chk("rst_valid", 64'({dv0, dv1, dv2, fv0, fv1, fv2}), 64'd0);
      chk("rst_fins", 64'({fins0, fins1, fins2}), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("init");

      foreach (vecs[i]) begin
         @(negedge clk);
         we = vecs[i].we; waddr = vecs[i].waddr; din = vecs[i].din;
         re = vecs[i].re; raddr = vecs[i].raddr;
         fe = vecs[i].fe; faddr = vecs[i].faddr;
         @(posedge clk); #1;
         idle_inputs();
         chk($sformatf("v%0d_dout0", i), 64'(dout0), 64'(vecs[i].d0));
         chk($sformatf("v%0d_dout1", i), 64'(dout1), 64'(vecs[i].d1));
         chk($sformatf("v%0d_dv0", i), 64'(dv0), 64'(vecs[i].dv));
         chk($sformatf("v%0d_dv1", i), 64'(dv1), 64'(vecs[i].dv));
         chk($sformatf("v%0d_fins0", i), 64'(fins0), 64'(vecs[i].f0));
         chk($sformatf("v%0d_fins1", i), 64'(fins1), 64'(vecs[i].f1));
         chk($sformatf("v%0d_fv0", i), 64'(fv0), 64'(vecs[i].fv));
         chk($sformatf("v%0d_fv1", i), 64'(fv1), 64'(vecs[i].fv));
      end

      // Reset in the middle of a clear restarts the sweep from address 0.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      chk("mid_ready_c100", 64'({rdy0, rdy1}), 64'd0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_ready_rst", 64'({rdy0, rdy1}), 64'd0);
      rst_n = 1'b1;
      we = 1'b1; waddr = 8'h40; din = 8'hEE;
      re = 1'b1; raddr = 8'h40; fe = 1'b1; faddr = 8'h40;
      wait_ready("mid");

      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         re = 1'b1; raddr = 8'(a);
         @(posedge clk); #1;
         re = 1'b0;
         chk($sformatf("clr_dout0_%02h", a), 64'(dout0), 64'd0);
         chk($sformatf("clr_dout1_%02h", a), 64'(dout1), 64'd0);
      end

      // No-clear build: ready on first edge, contents survive reset.
      @(negedge clk);
      rst_n2 = 1'b1;
      @(posedge clk); #1;
      chk("nclr_ready_first", 64'(rdy2), 64'd1);
      @(negedge clk);
      we = 1'b1; waddr = 8'h05; din = 8'h77;
      @(negedge clk);
      we = 1'b0;
      rst_n2 = 1'b0;
      #1;
      chk("nclr_ready_rst", 64'(rdy2), 64'd0);
      repeat (2) @(negedge clk);
      rst_n2 = 1'b1;
      @(posedge clk); #1;
      chk("nclr_ready_again", 64'(rdy2), 64'd1);
      @(negedge clk);
      re = 1'b1; raddr = 8'h05;
      @(posedge clk); #1;
      re = 1'b0;
      chk("nclr_dout", 64'(dout2), 64'h77);
      chk("nclr_dv", 64'(dv2), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
